time_keeper: RTL and testbench
==============================

# time_keeper

Time-of-day counter for the alarm clock, directly downstream of the clock divider. It consumes the divider's 1 Hz square wave (`sec_clk`), synchronizes it into the `clk` domain, and advances an hh:mm:ss count once per rising edge. It also provides set-mode adjustment, a parallel load, and alarm compare/ring logic for the display and buzzer stages.

## Interface
- `HOUR_MAX`, 24: hour modulus; hours count 0..HOUR_MAX-1. Legal values are 12 and 24.
- `SNOOZE_MIN`, 5: snooze delay in minutes; legal range 1..59. Only used when snooze is compiled in.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sec_clk`  in  1  divided clock from the divider; each rising edge is one second. It is asynchronous to `clk` in phase.
- `set_en`  in  1  adjust mode; while high, seconds do not advance.
- `inc_min`  in  1  one-clk pulse; +1 minute; honoured only while `set_en` is high.
- `inc_hour`  in  1  one-clk pulse; +1 hour; honoured only while `set_en` is high.
- `load`  in  1  one-clk pulse; loads `load_hh:load_mm:00`.
- `load_hh`  in  5  hour value to load.
- `load_mm`  in  6  minute value to load.
- `alarm_hh`  in  5  alarm hour.
- `alarm_mm`  in  6  alarm minute.
- `alarm_arm`  in  1  alarm enable (level).
- `alarm_ack`  in  1  one-clk pulse; silences the ring.
- `snooze`  in  1  one-clk pulse; snooze request.
- `hh`  out  5  hours, binary.
- `mm`  out  6  minutes, binary.
- `ss`  out  6  seconds, binary.
- `sec_pulse`  out  1  one-clk pulse on each applied second advance.
- `alarm_ring`  out  1  level; alarm is sounding.

## Operation
- Input path: `sec_clk` → s1 → s2 → s3 flops. `tick = s2 & ~s3`.
- Priority per clk edge:
  - `reset` (asynchronous) has highest priority.
  - `load` overrides `set_en`/`inc_*`.
  - `set_en` with `inc_*` overrides a tick.
  - A tick is applied only when none of the above act.
- Reset: `hh`, `mm` and `ss` go to 0. `sec_pulse`, `alarm_ring`, the sync flops and the snooze state all clear.
- Tick, when not in set mode and no load is active:
  - `ss` goes to `ss+1`.
  - 59 wraps to 0 and carries into `mm`.
  - `mm` 59 wraps to 0 and carries into `hh`.
  - `hh` at HOUR_MAX-1 wraps to 0.
  - `sec_pulse` is 1 for that cycle.
- A tick arriving while `set_en` is high is discarded, not queued. `sec_pulse` stays 0.
- `inc_min`:
  - `mm` wraps 59→0 with no hour carry.
  - `ss` is forced to 0.
- `inc_hour`:
  - `hh` wraps HOUR_MAX-1→0.
  - `ss` is forced to 0.
- `inc_min` and `inc_hour` in the same cycle are both applied.
- `load`:
  - If `load_hh < HOUR_MAX` and `load_mm < 60`, then `hh:mm:ss` takes `load_hh:load_mm:00`.
  - Otherwise the load is ignored and the time is unchanged.
- Alarm match is evaluated only on an applied tick whose result has `ss==0`, `hh==alarm_hh`, `mm==alarm_mm` and `alarm_arm==1`. Load and inc never trigger a match.
- `alarm_ring` sets on the same edge the matching time appears.
- `alarm_ring` clears on `alarm_ack` or when `alarm_arm` is low.
- If a match and `alarm_ack` occur in the same cycle, the match wins and `alarm_ring` stays 1.

## Timing
- A rising edge of `sec_clk` first sampled high at clk edge N produces these changes at edge N+2:
  - `tick`
  - updated `hh:mm:ss`
  - `sec_pulse`
  - `alarm_ring` set
- All outputs are registered. There is no combinational path from input to output.
- Load, inc, ack and snooze take effect on the edge where they are sampled high. The result is visible the next cycle.
- `sec_clk` high and low phases must each be at least 2 clk periods.
- Reset asserted mid-operation clears everything immediately. The first tick after release requires a new `sec_clk` rising edge, because the s1..s3 flops reset to 0.
  - If `sec_clk` is already high at release, that level counts as one edge.

## Configuration
- Macro: `TIME_KEEPER_SNOOZE_EN`.
- Defined:
  - `snooze` while `alarm_ring`=1 clears `alarm_ring` and latches target = (`hh:mm` + SNOOZE_MIN minutes) mod the day.
  - An applied tick reaching target:00 sets `alarm_ring` again.
  - The snooze target is cancelled by `alarm_ack`, by `alarm_arm` low, or by `load`.
  - `snooze` while not ringing has no effect.
  - A snooze ring and the primary alarm at the same time produce a single ring.
- Undefined:
  - The `snooze` port is present but ignored.
  - No snooze registers exist.

## Test plan
- Rollover: load 23:59, wait 59 `sec_clk` edges → `23:59:59`; next edge → `00:00:00` with `sec_pulse` high for 1 cycle, exactly 2 clk edges after first sample.
- Set mode: `set_en`=1, 3 `sec_clk` edges, `inc_min` at `mm`=59 with `hh`=7 → `07:00:00`, `ss` frozen, `sec_pulse` never high.
- Invalid load: `load` 24:10 when HOUR_MAX=24 → time unchanged; `load` 12:60 → unchanged; `load` 12:30 → `12:30:00`.
- Alarm: alarm 06:30 armed, time 06:29:58 → `alarm_ring` rises on the edge `ss` becomes 0 at 06:30; `alarm_ack` → 0 next cycle; loading 06:30 does not ring.
- Snooze (macro on, SNOOZE_MIN=5): ring at 06:30:00, `snooze` at 06:30:10 → ring clears; ring again at 06:35:00; `alarm_arm` low → ring clears.
- Async reset mid-count at 10:20:30 with `alarm_ring`=1 → all outputs 0 without a clk edge.

Source files
------------

// File: rtl/time_keeper.sv
// time_keeper: hh:mm:ss time-of-day counter with set mode, parallel load and alarm/ring logic
// Advances once per synchronized rising edge of sec_clk_i; all outputs are registered.
// Optional snooze support is compiled in with `define TIME_KEEPER_SNOOZE_EN.
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   sec_clk_i                  1 Hz square wave from the divider (asynchronous phase)
//   set_en_i, inc_min_i/hour_i adjust mode and +1 minute / +1 hour pulses
//   load_i, load_hh_i/mm_i     parallel load of hh:mm:00 (ignored when out of range)
//   alarm_hh_i/mm_i, alarm_arm_i, alarm_ack_i, snooze_i   alarm control
//   hh_o, mm_o, ss_o           current time, binary
//   sec_pulse_o                one-cycle pulse per applied second
//   alarm_ring_o               alarm sounding level
module time_keeper #(
  parameter int HOUR_MAX   = 24,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_clk_i,
  input  logic       set_en_i,
  input  logic       inc_min_i,
  input  logic       inc_hour_i,
  input  logic       load_i,
  input  logic [4:0] load_hh_i,
  input  logic [5:0] load_mm_i,
  input  logic [4:0] alarm_hh_i,
  input  logic [5:0] alarm_mm_i,
  input  logic       alarm_arm_i,
  input  logic       alarm_ack_i,
  input  logic       snooze_i,
  output logic [4:0] hh_o,
  output logic [5:0] mm_o,
  output logic [5:0] ss_o,
  output logic       sec_pulse_o,
  output logic       alarm_ring_o
);
  localparam logic [4:0] H_LAST = 5'(HOUR_MAX - 1);
  logic [2:0] sync_q;
  logic [4:0] hh_q, hh_d;
  logic [5:0] mm_q, mm_d, ss_q, ss_d;
  logic       pulse_q, ring_q, ring_d;
  logic       tick, ld_ok, adj, apply, ss_wrap, mm_wrap, hh_wrap, match;
  // sync_q[0..2] are s1..s3; tick marks the synchronized rising edge
  assign tick    = sync_q[1] & ~sync_q[2];
  assign ld_ok   = load_i && load_hh_i <= H_LAST && load_mm_i < 6'd60;
  assign adj     = set_en_i && !load_i && (inc_min_i || inc_hour_i);
  assign apply   = tick && !set_en_i && !load_i;
  assign ss_wrap = ss_q == 6'd59;
  assign mm_wrap = mm_q == 6'd59;
  assign hh_wrap = hh_q == H_LAST;
  always_comb begin
    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    if (ld_ok) begin
      hh_d = load_hh_i;
      mm_d = load_mm_i;
      ss_d = '0;
    end else if (adj) begin
      mm_d = !inc_min_i ? mm_q : mm_wrap ? '0 : mm_q + 6'd1;
      hh_d = !inc_hour_i ? hh_q : hh_wrap ? '0 : hh_q + 5'd1;
      ss_d = '0;
    end else if (apply) begin
      ss_d = ss_wrap ? '0 : ss_q + 6'd1;
      mm_d = !ss_wrap ? mm_q : mm_wrap ? '0 : mm_q + 6'd1;
      hh_d = !(ss_wrap && mm_wrap) ? hh_q : hh_wrap ? '0 : hh_q + 5'd1;
    end
  end
  // only a real second advance can hit the alarm minute, never a load or inc
  assign match = apply && ss_d == '0 && hh_d == alarm_hh_i && mm_d == alarm_mm_i && alarm_arm_i;
`ifdef TIME_KEEPER_SNOOZE_EN
  logic       sn_act_q, sn_act_d, sn_take, sn_hit;
  logic [4:0] sn_hh_q, sn_hh_d;
  logic [5:0] sn_mm_q, sn_mm_d;
  logic [6:0] sn_sum;
  assign sn_sum  = {1'b0, mm_q} + 7'(SNOOZE_MIN);
  assign sn_take = snooze_i && ring_q;
  assign sn_hit  = apply && sn_act_q && alarm_arm_i && ss_d == '0 && hh_d == sn_hh_q && mm_d == sn_mm_q;
  always_comb begin
    sn_act_d = (alarm_ack_i || !alarm_arm_i || load_i) ? 1'b0 : sn_take ? 1'b1 : sn_hit ? 1'b0 : sn_act_q;
    sn_mm_d  = !sn_take ? sn_mm_q : sn_sum >= 7'd60 ? 6'(sn_sum - 7'd60) : sn_sum[5:0];
    sn_hh_d  = !sn_take ? sn_hh_q : sn_sum < 7'd60 ? hh_q : hh_wrap ? '0 : hh_q + 5'd1;
    // a new match outranks any clear request in the same cycle
    ring_d   = (match || sn_hit) ? 1'b1 : (sn_take || alarm_ack_i || !alarm_arm_i) ? 1'b0 : ring_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sn_act_q <= 1'b0;
      sn_hh_q  <= '0;
      sn_mm_q  <= '0;
    end else begin
      sn_act_q <= sn_act_d;
      sn_hh_q  <= sn_hh_d;
      sn_mm_q  <= sn_mm_d;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze_i | (SNOOZE_MIN == 0);
  // a new match outranks ack in the same cycle
  assign ring_d = match ? 1'b1 : (alarm_ack_i || !alarm_arm_i) ? 1'b0 : ring_q;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      hh_q    <= '0;
      mm_q    <= '0;
      ss_q    <= '0;
      pulse_q <= 1'b0;
      ring_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], sec_clk_i};
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      pulse_q <= apply;
      ring_q  <= ring_d;
    end
  end
  assign hh_o         = hh_q;
  assign mm_o         = mm_q;
  assign ss_o         = ss_q;
  assign sec_pulse_o  = pulse_q;
  assign alarm_ring_o = ring_q;
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed self-checking bench for time_keeper
module tb_time_keeper;
  logic       clk = 1'b0, reset = 1'b1, sec_clk = 1'b0;
  logic       set_en = 1'b0, inc_min = 1'b0, inc_hour = 1'b0, load = 1'b0;
  logic [4:0] load_hh = '0, alarm_hh = '0;
  logic [5:0] load_mm = '0, alarm_mm = '0;
  logic       alarm_arm = 1'b0, alarm_ack = 1'b0, snooze = 1'b0;
  logic [4:0] hh;
  logic [5:0] mm, ss;
  logic       sec_pulse, alarm_ring;
  int         n_checks = 0, n_fail = 0, pulse_cnt = 0, p0;
  time_keeper #(.HOUR_MAX(24), .SNOOZE_MIN(5)) dut (
    .clk(clk), .reset(reset), .sec_clk_i(sec_clk), .set_en_i(set_en),
    .inc_min_i(inc_min), .inc_hour_i(inc_hour), .load_i(load),
    .load_hh_i(load_hh), .load_mm_i(load_mm), .alarm_hh_i(alarm_hh),
    .alarm_mm_i(alarm_mm), .alarm_arm_i(alarm_arm), .alarm_ack_i(alarm_ack),
    .snooze_i(snooze), .hh_o(hh), .mm_o(mm), .ss_o(ss),
    .sec_pulse_o(sec_pulse), .alarm_ring_o(alarm_ring)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (sec_pulse) pulse_cnt <= pulse_cnt + 1;
  function automatic int tod();
    return int'(hh) * 10000 + int'(mm) * 100 + int'(ss);
  endfunction
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic sec_tick();
    sec_clk = 1'b1;
    repeat (3) @(negedge clk);
    sec_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) sec_tick();
  endtask
  task automatic do_load(input int h, input int m);
    load_hh = 5'(h);
    load_mm = 6'(m);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("reset_time", tod(), 0);
    check("reset_pulse", int'(sec_pulse), 0);
    check("reset_ring", int'(alarm_ring), 0);
    reset = 1'b0;
    @(negedge clk);
    do_load(24, 10);
    check("load_bad_hour", tod(), 0);
    do_load(12, 60);
    check("load_bad_min", tod(), 0);
    do_load(12, 30);
    check("load_ok", tod(), 123000);
    do_load(23, 59);
    ticks(59);
    check("roll_pre", tod(), 235959);
    sec_clk = 1'b1;
    repeat (2) @(negedge clk);
    check("roll_n1_time", tod(), 235959);
    check("roll_n1_pulse", int'(sec_pulse), 0);
    @(negedge clk);
    check("roll_n2_time", tod(), 0);
    check("roll_n2_pulse", int'(sec_pulse), 1);
    @(negedge clk);
    check("roll_pulse_len", int'(sec_pulse), 0);
    sec_clk = 1'b0;
    repeat (2) @(negedge clk);
    do_load(7, 59);
    ticks(2);
    check("set_pre", tod(), 75902);
    set_en = 1'b1;
    p0 = pulse_cnt;
    ticks(3);
    check("set_frozen", tod(), 75902);
    check("set_no_pulse", pulse_cnt - p0, 0);
    inc_min = 1'b1;
    @(negedge clk);
    inc_min = 1'b0;
    check("inc_min_wrap", tod(), 70000);
    inc_min = 1'b1;
    inc_hour = 1'b1;
    @(negedge clk);
    inc_min = 1'b0;
    inc_hour = 1'b0;
    check("inc_both", tod(), 80100);
    set_en = 1'b0;
    inc_min = 1'b1;
    @(negedge clk);
    inc_min = 1'b0;
    check("inc_no_set", tod(), 80100);
    alarm_hh = 5'd6;
    alarm_mm = 6'd30;
    alarm_arm = 1'b1;
    do_load(6, 29);
    ticks(59);
    check("alarm_pre_ring", int'(alarm_ring), 0);
    sec_clk = 1'b1;
    repeat (2) @(negedge clk);
    check("alarm_n1_ring", int'(alarm_ring), 0);
    @(negedge clk);
    check("alarm_n2_time", tod(), 63000);
    check("alarm_n2_ring", int'(alarm_ring), 1);
    sec_clk = 1'b0;
    repeat (3) @(negedge clk);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    check("alarm_ack", int'(alarm_ring), 0);
    do_load(6, 30);
    check("alarm_load_time", tod(), 63000);
    check("alarm_load_no_ring", int'(alarm_ring), 0);
    alarm_mm = 6'd31;
    ticks(59);
    sec_clk = 1'b1;
    repeat (2) @(negedge clk);
    alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    check("match_vs_ack_time", tod(), 63100);
    check("match_vs_ack_ring", int'(alarm_ring), 1);
    sec_clk = 1'b0;
    repeat (3) @(negedge clk);
`ifndef TIME_KEEPER_SNOOZE_EN
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    check("snooze_ignored", int'(alarm_ring), 1);
`endif
    alarm_arm = 1'b0;
    @(negedge clk);
    check("arm_low_clear", int'(alarm_ring), 0);
    alarm_arm = 1'b1;
`ifdef TIME_KEEPER_SNOOZE_EN
    alarm_mm = 6'd30;
    do_load(6, 29);
    ticks(60);
    check("snz_first_ring", int'(alarm_ring), 1);
    ticks(10);
    check("snz_at", tod(), 63010);
    snooze = 1'b1;
    @(negedge clk);
    snooze = 1'b0;
    check("snz_clear", int'(alarm_ring), 0);
    ticks(289);
    check("snz_pre_time", tod(), 63459);
    check("snz_pre_ring", int'(alarm_ring), 0);
    sec_tick();
    check("snz_ring_time", tod(), 63500);
    check("snz_ring", int'(alarm_ring), 1);
    alarm_arm = 1'b0;
    @(negedge clk);
    check("snz_arm_low", int'(alarm_ring), 0);
    alarm_arm = 1'b1;
`endif
    alarm_hh = 5'd10;
    alarm_mm = 6'd20;
    do_load(10, 19);
    ticks(90);
    check("rst_pre_time", tod(), 102030);
    check("rst_pre_ring", int'(alarm_ring), 1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_time", tod(), 0);
    check("rst_async_ring", int'(alarm_ring), 0);
    check("rst_async_pulse", int'(sec_pulse), 0);
    sec_clk = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_high_edge", tod(), 1);
    sec_clk = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
